// File: rtl/posit_accum_seq.sv
// Job sequencer in front of a pipelined posit accumulator: clear, stream terms, drain, report.
// Optional NaR early-abort path is compiled in with POSIT_ACCUM_SEQ_NAR_ABORT_EN.
module posit_accum_seq #(
  parameter int N     = 32,
  parameter int ES    = 2,
  parameter int LEN_W = 16,
  parameter int LAT   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [N-1:0]     term_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_inf,
  output logic             res_zero,
  output logic             acc_rst,
  output logic             acc_start,
  output logic [N-1:0]     acc_in1,
  input  logic [N-1:0]     acc_result,
  input  logic             acc_inf,
  input  logic             acc_zero,
  output logic             busy
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  generate
    if (ES < 0 || ES > N - 3 || LAT < 1) begin : g_param_err
      $error("posit_accum_seq: unsupported ES/LAT for this N");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
`ifdef POSIT_ACCUM_SEQ_NAR_ABORT_EN
    , S_FLUSH
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic             acc_rst_q, acc_rst_d;
  logic             acc_start_q, acc_start_d;
  logic [N-1:0]     acc_in1_q, acc_in1_d;
  logic             res_valid_q, res_valid_d;
  logic [N-1:0]     res_data_q, res_data_d;
  logic             res_inf_q, res_inf_d;
  logic             res_zero_q, res_zero_d;

  logic term_hs;
  logic last_term;

  assign job_ready = (state_q == S_IDLE);
`ifdef POSIT_ACCUM_SEQ_NAR_ABORT_EN
  assign term_ready = (state_q == S_FEED) || (state_q == S_FLUSH);
`else
  assign term_ready = (state_q == S_FEED);
`endif
  assign busy      = (state_q != S_IDLE);
  assign term_hs   = term_valid && term_ready;
  // len_q is nonzero whenever terms are taken, so len_q-1 cannot wrap
  assign last_term = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    acc_rst_d   = 1'b0;
    acc_start_d = 1'b0;
    acc_in1_d   = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_inf_d   = res_inf_q;
    res_zero_d  = res_zero_q;
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          len_d   = job_len;
          cnt_d   = '0;
          drn_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_rst_d = 1'b1;
        state_d   = (len_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
`ifdef POSIT_ACCUM_SEQ_NAR_ABORT_EN
        if (acc_inf) begin
          if (term_hs) cnt_d = cnt_q + LEN_W'(1);
          if (term_hs && last_term) begin
            res_valid_d = 1'b1;
            res_data_d  = NAR;
            res_inf_d   = 1'b1;
            res_zero_d  = 1'b0;
            state_d     = S_HOLD;
          end else begin
            state_d = S_FLUSH;
          end
        end else
`endif
        if (term_hs) begin
          acc_start_d = 1'b1;
          acc_in1_d   = term_data;
          cnt_d       = cnt_q + LEN_W'(1);
          if (last_term) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drn_q == DW'(LAT - 1)) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_result;
          res_inf_d   = acc_inf;
          res_zero_d  = acc_zero;
          state_d     = S_HOLD;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef POSIT_ACCUM_SEQ_NAR_ABORT_EN
      // Remaining terms are swallowed so the upstream stream stays aligned to job boundaries
      S_FLUSH: begin
        if (term_hs) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_term) begin
            res_valid_d = 1'b1;
            res_data_d  = NAR;
            res_inf_d   = 1'b1;
            res_zero_d  = 1'b0;
            state_d     = S_HOLD;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drn_q       <= '0;
      acc_rst_q   <= 1'b0;
      acc_start_q <= 1'b0;
      acc_in1_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_inf_q   <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      acc_rst_q   <= acc_rst_d;
      acc_start_q <= acc_start_d;
      acc_in1_q   <= acc_in1_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_inf_q   <= res_inf_d;
      res_zero_q  <= res_zero_d;
    end
  end

  assign acc_rst   = acc_rst_q;
  assign acc_start = acc_start_q;
  assign acc_in1   = acc_in1_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_inf   = res_inf_q;
  assign res_zero  = res_zero_q;

endmodule
